// File: rtl/multicycle_cpu_pkg.sv
// Shared types and encodings for the multicycle CPU: FSM states, ALU ops, opcode/funct fields.
// The MUL state exists only when MUL_EN is defined.
package multicycle_cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
`ifdef MUL_EN
        , ST_MUL  = 3'd6
`endif
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SLT
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle CPU; all arithmetic wraps modulo 2^XLEN.
module mc_alu
    import multicycle_cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e                op_i,
    input  logic signed [XLEN-1:0] a_i,
    input  logic signed [XLEN-1:0] b_i,
    output logic signed [XLEN-1:0] y_o
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_SLL: y_o = a_i << shamt;
            // both operands are signed, so this is a signed compare
            ALU_SLT: y_o = (a_i < b_i) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle RV32-subset CPU: FETCH/DECODE/EXEC/WB FSM, register file, optional iterative multiplier.
// Define MUL_EN to enable the MUL instruction (shift-add, XLEN cycles in state MUL).
module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     imem_req_o,
    output logic [PC_W-1:0]          imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_rdata_i,
    output logic                     busy_o,
    output logic                     halted_o,
    output logic                     illegal_o,
    output logic                     retired_o,
    output logic [31:0]              retire_cnt_o,
    input  logic [$clog2(NREG)-1:0]  dbg_raddr_i,
    output logic [XLEN-1:0]          dbg_rdata_o
);

    localparam int         RA_W   = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);
`ifdef MUL_EN
    localparam int              MC_W     = $clog2(XLEN);
    localparam logic [MC_W-1:0] MUL_LAST = MC_W'(XLEN - 1);
`endif

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [31:0]            instr_q, instr_d;
    logic signed [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic signed [XLEN-1:0] result_q, result_d;
    logic                   wr_q, wr_d, ill_q, ill_d, ecall_q, ecall_d;
    logic                   illegal_q, illegal_d;
    logic [31:0]            retire_cnt_q, retire_cnt_d;
    logic signed [XLEN-1:0] regs_q [NREG];
    logic signed [XLEN-1:0] regs_d [NREG];
`ifdef MUL_EN
    logic [XLEN-1:0]        mul_acc_q, mul_acc_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [MC_W-1:0]        mul_cnt_q, mul_cnt_d;
    logic                   is_mul;
`endif

    logic [6:0]             opcode, funct7;
    logic [2:0]             funct3;
    logic [RA_W-1:0]        rd_idx, rs1_idx, rs2_idx;
    logic                   rd_ok, rs1_ok, rs2_ok;
    alu_op_e                alu_op;
    logic                   use_imm, legal, is_ecall;
    logic signed [XLEN-1:0] alu_b, alu_y;

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];
    assign rd_idx  = instr_q[RA_W+6:7];
    assign rs1_idx = instr_q[RA_W+14:15];
    assign rs2_idx = instr_q[RA_W+19:20];
    assign rd_ok   = ({1'b0, instr_q[11:7]}  < NREG_L);
    assign rs1_ok  = ({1'b0, instr_q[19:15]} < NREG_L);
    assign rs2_ok  = ({1'b0, instr_q[24:20]} < NREG_L);

    // Instruction decode; anything not recognised falls through as illegal
    always_comb begin
        alu_op   = ALU_ADD;
        use_imm  = 1'b0;
        legal    = 1'b0;
        is_ecall = 1'b0;
`ifdef MUL_EN
        is_mul   = 1'b0;
`endif
        if (instr_q == ECALL_INSN) begin
            legal    = 1'b1;
            is_ecall = 1'b1;
        end else if (opcode == OPC_OP) begin
            legal = rd_ok && rs1_ok && rs2_ok;
            case ({funct7, funct3})
                {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
                {F7_ALT,  F3_ADD_SUB}: alu_op = ALU_SUB;
                {F7_BASE, F3_SLL}:     alu_op = ALU_SLL;
                {F7_BASE, F3_SLT}:     alu_op = ALU_SLT;
                {F7_BASE, F3_XOR}:     alu_op = ALU_XOR;
                {F7_BASE, F3_OR}:      alu_op = ALU_OR;
                {F7_BASE, F3_AND}:     alu_op = ALU_AND;
`ifdef MUL_EN
                {F7_MULDIV, F3_ADD_SUB}: is_mul = 1'b1;
`endif
                default:               legal  = 1'b0;
            endcase
        end else if (opcode == OPC_OP_IMM) begin
            use_imm = 1'b1;
            legal   = rd_ok && rs1_ok;
            case (funct3)
                F3_ADD_SUB: alu_op = ALU_ADD;
                F3_OR:      alu_op = ALU_OR;
                F3_AND:     alu_op = ALU_AND;
                default:    legal  = 1'b0;
            endcase
        end
    end

    assign alu_b = use_imm ? imm_q : rs2_q;

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op_i (alu_op),
        .a_i  (rs1_q),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_FETCH;
            ST_FETCH:  if (imem_ack_i) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
`ifdef MUL_EN
            ST_EXEC:   state_d = (legal && is_mul) ? ST_MUL : ST_WB;
            ST_MUL:    if (mul_cnt_q == MUL_LAST) state_d = ST_WB;
`else
            ST_EXEC:   state_d = ST_WB;
`endif
            ST_WB:     state_d = ecall_q ? ST_HALT : ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem_req_o = (state_q == ST_FETCH);
        busy_o     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted_o   = (state_q == ST_HALT);
        retired_o  = (state_q == ST_WB);
    end

    assign imem_addr_o  = pc_q;
    assign illegal_o    = illegal_q;
    assign retire_cnt_o = retire_cnt_q;
    assign dbg_rdata_o  = regs_q[dbg_raddr_i];

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        result_d     = result_q;
        wr_d         = wr_q;
        ill_d        = ill_q;
        ecall_d      = ecall_q;
        illegal_d    = illegal_q;
        retire_cnt_d = retire_cnt_q;
        regs_d       = regs_q;
`ifdef MUL_EN
        mul_acc_d    = mul_acc_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_cnt_d    = mul_cnt_q;
`endif
        case (state_q)
            ST_FETCH: if (imem_ack_i) instr_d = imem_rdata_i;
            ST_DECODE: begin
                rs1_d = regs_q[rs1_idx];
                rs2_d = regs_q[rs2_idx];
                imm_d = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
            end
            ST_EXEC: begin
                result_d = alu_y;
                wr_d     = legal && !is_ecall && (instr_q[11:7] != 5'd0);
                ill_d    = !legal;
                ecall_d  = is_ecall;
`ifdef MUL_EN
                mul_acc_d = '0;
                mul_a_d   = rs1_q;
                mul_b_d   = rs2_q;
                mul_cnt_d = '0;
`endif
            end
`ifdef MUL_EN
            // One multiplier bit per cycle; low XLEN bits are sign-agnostic
            ST_MUL: begin
                mul_acc_d = mul_b_q[0] ? (mul_acc_q + mul_a_q) : mul_acc_q;
                mul_a_d   = mul_a_q << 1;
                mul_b_d   = mul_b_q >> 1;
                mul_cnt_d = mul_cnt_q + MC_W'(1);
                result_d  = mul_acc_d;
            end
`endif
            ST_WB: begin
                if (wr_q) regs_d[rd_idx] = result_q;
                illegal_d    = illegal_q | ill_q;
                pc_d         = pc_q + PC_W'(4);
                retire_cnt_d = retire_cnt_q + 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            result_q     <= '0;
            wr_q         <= 1'b0;
            ill_q        <= 1'b0;
            ecall_q      <= 1'b0;
            illegal_q    <= 1'b0;
            retire_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
`ifdef MUL_EN
            mul_acc_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_cnt_q    <= '0;
`endif
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            result_q     <= result_d;
            wr_q         <= wr_d;
            ill_q        <= ill_d;
            ecall_q      <= ecall_d;
            illegal_q    <= illegal_d;
            retire_cnt_q <= retire_cnt_d;
            regs_q       <= regs_d;
`ifdef MUL_EN
            mul_acc_q    <= mul_acc_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_cnt_q    <= mul_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu at XLEN=16: ALU vector table, fetch latency, illegal/halt, MUL, reset mid-fetch.
// Expectations for the MUL program follow the MUL_EN macro.
module tb_multicycle_cpu;

    localparam int XLEN = 16;
    localparam int NREG = 32;
    localparam int PC_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic              imem_req_o;
    logic [PC_W-1:0]   imem_addr_o;
    logic              imem_ack_i = 1'b0;
    logic [31:0]       imem_rdata_i = '0;
    logic              busy_o, halted_o, illegal_o, retired_o;
    logic [31:0]       retire_cnt_o;
    logic [4:0]        dbg_raddr_i = '0;
    logic [XLEN-1:0]   dbg_rdata_o;

    multicycle_cpu #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W), .RESET_PC('0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .busy_o(busy_o), .halted_o(halted_o), .illegal_o(illegal_o),
        .retired_o(retired_o), .retire_cnt_o(retire_cnt_o),
        .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        int          rd;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        int          rd;
        logic [15:0] val;
    } sb_t;

    int          n_cmp = 0;
    int          n_err = 0;
    sb_t         sb_q[$];
    logic [31:0] imem [64];
    int          ack_delay = 0;
    bit          mem_en = 1'b1;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] opc);
        return {12'(imm), 5'(rs1), f3, 5'(rd), opc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_sb(input logic [31:0] pc, input logic [31:0] cnt, input int rd,
                           input logic [15:0] val);
        sb_t e;
        e.pc = pc; e.cnt = cnt; e.rd = rd; e.val = val;
        sb_q.push_back(e);
    endtask

    // Instruction memory responder with programmable ack latency
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (mem_en) begin
                if (imem_req_o) begin
                    if (wait_cnt >= ack_delay) begin
                        imem_ack_i   = 1'b1;
                        imem_rdata_i = imem[imem_addr_o[7:2]];
                        wait_cnt     = 0;
                    end else begin
                        imem_ack_i = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    imem_ack_i = 1'b0;
                    wait_cnt   = 0;
                end
            end
        end
    end

    // Retirement monitor: pops the scoreboard on each retired_o pulse
    initial begin
        sb_t e;
        forever begin
            @(negedge clk_i);
            if (retired_o) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: retirement at pc 0x%0h with no expected entry", imem_addr_o);
                end else begin
                    e = sb_q.pop_front();
                    check("ret_pc", imem_addr_o, e.pc);
                    check("ret_cnt", retire_cnt_o, e.cnt);
                    dbg_raddr_i = 5'(e.rd);
                    @(negedge clk_i);
                    check($sformatf("reg_x%0d", e.rd), {16'h0, dbg_rdata_o}, {16'h0, e.val});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        sb_q.delete();
        #1;
        check("rst_req", imem_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_illegal", illegal_o, 0);
        check("rst_retired", retired_o, 0);
        check("rst_cnt", retire_cnt_o, 0);
        check("rst_pc", imem_addr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Pulses start_i; returns at the negedge of the first FETCH cycle
    task automatic start_cpu();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("halt_reached", halted_o, 1);
        @(negedge clk_i);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic first_insn_latency(input int delay, input int exp_n);
        int n;
        clear_mem();
        imem[0] = enc_i(5, 0, 3'b000, 1, OP_I);
        imem[1] = ECALL;
        ack_delay = delay;
        do_reset();
        push_sb(0, 0, 1, 16'd5);
        push_sb(4, 1, 0, 16'd0);
        start_cpu();
        n = 1;
        while (!retired_o && n < 50) begin
            if (imem_req_o) check("fetch_addr_stable", imem_addr_o, 0);
            @(negedge clk_i);
            n++;
        end
        check($sformatf("retire_cycle_d%0d", delay), n, exp_n);
        @(negedge clk_i);
        check("cnt_after_first", retire_cnt_o, 1);
        wait_halt(100);
        check("cnt_after_ecall", retire_cnt_o, 2);
    endtask

    vec_t vecs[15];

    initial begin
        int n, rets, n_ecall, pc;

        vecs[0]  = '{enc_r(7'h00, 2, 1, 3'b000, 3),  3,  16'h0000};
        vecs[1]  = '{enc_r(7'h00, 2, 1, 3'b010, 4),  4,  16'h0001};
        vecs[2]  = '{enc_r(7'h00, 1, 2, 3'b001, 5),  5,  16'h8000};
        vecs[3]  = '{enc_r(7'h20, 1, 2, 3'b000, 6),  6,  16'h0002};
        vecs[4]  = '{enc_r(7'h00, 2, 1, 3'b111, 7),  7,  16'h0001};
        vecs[5]  = '{enc_r(7'h00, 2, 1, 3'b110, 8),  8,  16'hFFFF};
        vecs[6]  = '{enc_r(7'h00, 2, 1, 3'b100, 9),  9,  16'hFFFE};
        vecs[7]  = '{enc_i(12'h0F0, 1, 3'b111, 10, OP_I), 10, 16'h00F0};
        vecs[8]  = '{enc_i(-16, 2, 3'b110, 11, OP_I),     11, 16'hFFF1};
        vecs[9]  = '{enc_i(-2048, 1, 3'b000, 12, OP_I),   12, 16'hF7FF};
        vecs[10] = '{enc_r(7'h00, 1, 2, 3'b010, 13), 13, 16'h0000};
        vecs[11] = '{enc_r(7'h00, 1, 1, 3'b000, 0),  0,  16'h0000};
        vecs[12] = '{enc_i(2047, 1, 3'b000, 14, OP_I),    14, 16'h07FE};
        vecs[13] = '{enc_r(7'h00, 2, 1, 3'b001, 15), 15, 16'hFFFE};
        vecs[14] = '{enc_r(7'h20, 2, 0, 3'b000, 16), 16, 16'hFFFF};

        // Zero-wait and 3-cycle-delayed fetch of a single ADDI
        first_insn_latency(0, 4);
        first_insn_latency(3, 7);

        // ALU vector table: x1=-1, x2=1, then every vector, then ECALL
        clear_mem();
        ack_delay = 0;
        do_reset();
        imem[0] = enc_i(-1, 0, 3'b000, 1, OP_I);
        imem[1] = enc_i(1, 0, 3'b000, 2, OP_I);
        push_sb(0, 0, 1, 16'hFFFF);
        push_sb(4, 1, 2, 16'h0001);
        for (int i = 0; i < 15; i++) begin
            pc = 8 + 4 * i;
            imem[pc / 4] = vecs[i].instr;
            push_sb(32'(pc), 32'(i + 2), vecs[i].rd, vecs[i].exp);
        end
        imem[17] = ECALL;
        push_sb(68, 17, 0, 16'h0);
        start_cpu();
        wait_halt(400);
        check("alu_illegal", illegal_o, 0);
        check("alu_cnt", retire_cnt_o, 18);

        // Illegal opcode then ECALL; start_i must be ignored in HALT
        clear_mem();
        do_reset();
        imem[0] = enc_i(5, 0, 3'b000, 1, 7'b1111111);
        imem[1] = ECALL;
        push_sb(0, 0, 1, 16'h0);
        push_sb(4, 1, 0, 16'h0);
        start_cpu();
        wait_halt(100);
        check("ill_sticky", illegal_o, 1);
        check("ill_cnt", retire_cnt_o, 2);
        start_cpu();
        repeat (5) @(negedge clk_i);
        check("halt_hold", halted_o, 1);
        check("halt_busy", busy_o, 0);
        check("halt_req", imem_req_o, 0);
        check("halt_cnt", retire_cnt_o, 2);

        // MUL x3 = 7 * -3
        clear_mem();
        do_reset();
        imem[0] = enc_i(7, 0, 3'b000, 1, OP_I);
        imem[1] = enc_i(-3, 0, 3'b000, 2, OP_I);
        imem[2] = enc_r(7'h01, 2, 1, 3'b000, 3);
        imem[3] = ECALL;
        push_sb(0, 0, 1, 16'd7);
        push_sb(4, 1, 2, 16'hFFFD);
`ifdef MUL_EN
        push_sb(8, 2, 3, 16'hFFEB);
`else
        push_sb(8, 2, 3, 16'h0000);
`endif
        push_sb(12, 3, 0, 16'h0);
        start_cpu();
        n = 1; rets = 0; n_ecall = 0;
        while (!halted_o && n < 200) begin
            if (retired_o) begin
                rets++;
                if (rets == 4) n_ecall = n;
            end
            @(negedge clk_i);
            n++;
        end
        wait_halt(10);
`ifdef MUL_EN
        check("mul_ecall_cycle", n_ecall, 32);
        check("mul_illegal", illegal_o, 0);
`else
        check("mul_ecall_cycle", n_ecall, 16);
        check("mul_illegal", illegal_o, 1);
`endif

        // Reset asserted while the second fetch waits for its ack
        clear_mem();
        ack_delay = 0;
        do_reset();
        imem[0] = enc_i(5, 0, 3'b000, 1, OP_I);
        imem[1] = enc_i(9, 0, 3'b000, 2, OP_I);
        imem[2] = ECALL;
        push_sb(0, 0, 1, 16'd5);
        start_cpu();
        n = 1;
        while (!retired_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        ack_delay = 5;
        repeat (3) @(negedge clk_i);
        check("midfetch_req_pre", imem_req_o, 1);
        check("midfetch_addr_pre", imem_addr_o, 4);
        rst_i = 1'b1;
        #1;
        check("midfetch_req_drop", imem_req_o, 0);
        check("midfetch_pc_reset", imem_addr_o, 0);
        check("midfetch_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_en = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = enc_i(1, 0, 3'b000, 3, OP_I);
        dbg_raddr_i = 5'd1;
        repeat (3) @(negedge clk_i);
        check("late_ack_busy", busy_o, 0);
        check("late_ack_req", imem_req_o, 0);
        check("late_ack_cnt", retire_cnt_o, 0);
        check("late_ack_x1", {16'h0, dbg_rdata_o}, 0);
        imem_ack_i = 1'b0;
        mem_en = 1'b1;
        ack_delay = 0;
        push_sb(0, 0, 1, 16'd5);
        push_sb(4, 1, 2, 16'd9);
        push_sb(8, 2, 0, 16'h0);
        start_cpu();
        wait_halt(100);
        check("recover_cnt", retire_cnt_o, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
